csa_accum_sequencer: RTL

//  Multi-operand accumulation controller built around a 3:2 carry-save stage. Accepts a stream
//  of signed operands over valid/ready and keeps the running total in redundant form in two

---
 rtl/csa_accum_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/csa_accum_sequencer.sv
// rtl/csa_accum_sequencer.sv - carry-save multi-operand accumulator with one-cycle resolve
module csa_accum_sequencer #(
   parameter int WIDTH   = 32,
   parameter int MAX_OPS = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_of,
   output logic             out_trunc,
   output logic [$clog2(MAX_OPS):0] out_count
);

   localparam int G  = $clog2(MAX_OPS);
   localparam int IW = WIDTH + G;
   localparam logic [G:0] MAX_C = MAX_OPS[G:0];

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCUM,
      S_RESOLVE,
      S_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [IW-1:0]   sum_q, sum_d;
   logic [IW-1:0]   car_q, car_d;
   logic [G:0]      cnt_q, cnt_d;
   logic            last_q, last_d;
   logic            out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_sum_q, out_sum_d;
   logic            out_of_q, out_of_d;
   logic            out_trunc_q, out_trunc_d;
   logic [G:0]      out_count_q, out_count_d;

   logic            acc_en;
   logic [IW-1:0]   sum_base, car_base, x, fa_s, fa_c, total;
   logic [G:0]      cnt_inc;

   // rst_n is folded in so in_ready reads 0 while the block is held in reset
   assign in_ready = rst_n & ((state_q == S_IDLE) | (state_q == S_ACCUM)) & ~clr;
   assign acc_en   = in_valid & in_ready;

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_of    = out_of_q;
   assign out_trunc = out_trunc_q;
   assign out_count = out_count_q;

   // Full-adder row, resolve adder and next-state/output selection
   always_comb begin
      sum_base = (state_q == S_IDLE) ? '0 : sum_q;
      car_base = (state_q == S_IDLE) ? '0 : car_q;
      x        = {{G{in_data[WIDTH-1]}}, in_data};
      fa_s     = sum_base ^ car_base ^ x;
      fa_c     = (sum_base & car_base) | (sum_base & x) | (car_base & x);
      cnt_inc  = cnt_q + 1'b1;
      total    = sum_q + car_q;

      state_d     = state_q;
      sum_d       = sum_q;
      car_d       = car_q;
      cnt_d       = cnt_q;
      last_d      = last_q;
      out_valid_d = out_valid_q;
      out_sum_d   = out_sum_q;
      out_of_d    = out_of_q;
      out_trunc_d = out_trunc_q;
      out_count_d = out_count_q;

      if (clr) begin
         state_d     = S_IDLE;
         sum_d       = '0;
         car_d       = '0;
         cnt_d       = '0;
         out_valid_d = 1'b0;
      end else begin
         case (state_q)
            S_IDLE, S_ACCUM: begin
               if (acc_en) begin
                  sum_d  = fa_s;
                  // shifting drops the carry out of the top bit (mod 2^IW)
                  car_d  = fa_c << 1;
                  cnt_d  = cnt_inc;
                  last_d = in_last;
                  state_d = (in_last || cnt_inc == MAX_C) ? S_RESOLVE : S_ACCUM;
               end
            end
            S_RESOLVE: begin
               out_sum_d   = total[WIDTH-1:0];
               // fits in WIDTH only if all bits from the WIDTH-1 sign bit upward agree
               out_of_d    = ~((&total[IW-1:WIDTH-1]) | ~(|total[IW-1:WIDTH-1]));
               out_trunc_d = ~last_q;
               out_count_d = cnt_q;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d     = S_IDLE;
                  sum_d       = '0;
                  car_d       = '0;
                  cnt_d       = '0;
                  out_valid_d = 1'b0;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State, redundant accumulator and registered result outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         sum_q       <= '0;
         car_q       <= '0;
         cnt_q       <= '0;
         last_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_of_q    <= 1'b0;
         out_trunc_q <= 1'b0;
         out_count_q <= '0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         car_q       <= car_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_of_q    <= out_of_d;
         out_trunc_q <= out_trunc_d;
         out_count_q <= out_count_d;
      end
   end

endmodule
